// File: rtl/mul_operand_sequencer.sv
// rtl/mul_operand_sequencer.sv - operand/sign sequencer around a 16x16 unsigned multiplier array
//
// Purpose: accepts one multiply request at a time, drives the operand
// magnitudes to the array, waits MUL_LATENCY edges, sign-corrects the
// unsigned product and holds the selected 16-bit half until writeback takes it.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid/req_ready  request handshake
//   req_op               00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   req_a, req_b         operands, port bit 0 carries the MSB
//   mul_m1, mul_m2       operand magnitudes to the array (conventional order)
//   mul_product          unsigned array product, port bit 0 carries the MSB
//   rsp_valid/rsp_ready  response handshake
//   rsp_result           selected, sign-corrected result half
//   busy                 high while a request is in flight or held
module mul_operand_sequencer #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [15:0] mul_m1,
  output logic [15:0] mul_m2,
  input  logic [31:0] mul_product,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_m1;
  logic [15:0] r_m2;
  logic [15:0] r_result;
  logic        r_neg;
  logic        r_low;

  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [15:0] w_mag_a;
  logic [15:0] w_mag_b;
  logic [31:0] w_prod;
  logic [31:0] w_corr;
  logic        w_sign_a;
  logic        w_sign_b;
  logic        w_accept;

  // The ALU numbers bits MSB-first; flip into conventional LSB-at-0 order.
  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  assign w_a    = rev16(req_a);
  assign w_b    = rev16(req_b);
  assign w_prod = rev32(mul_product);

  // A is signed for every op except MULHU; B only for MUL and MULH.
  // MUL uses signed magnitudes too: the low half is signedness-independent.
  assign w_sign_a = (req_op != 2'b11) & w_a[15];
  assign w_sign_b = ~req_op[1] & w_b[15];
  // 0x8000 negates to itself, which is the correct unsigned magnitude.
  assign w_mag_a  = w_sign_a ? (~w_a + 16'd1) : w_a;
  assign w_mag_b  = w_sign_b ? (~w_b + 16'd1) : w_b;
  assign w_accept = req_valid & req_ready;
  // Two's-complement negation of zero wraps back to zero.
  assign w_corr   = r_neg ? (~w_prod + 32'd1) : w_prod;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)      w_next_state = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd1) w_next_state = S_DONE;
      S_DONE:  if (rsp_ready)     w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE:  req_ready = rst_n;
      S_WAIT:  busy = 1'b1;
      S_DONE:  begin
        rsp_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operand capture on accept, product capture on the last wait edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= 4'd0;
      r_m1     <= 16'd0;
      r_m2     <= 16'd0;
      r_result <= 16'd0;
      r_neg    <= 1'b0;
      r_low    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_m1  <= w_mag_a;
            r_m2  <= w_mag_b;
            r_neg <= w_sign_a ^ w_sign_b;
            r_low <= (req_op == 2'b00);
            r_cnt <= 4'(MUL_LATENCY);
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_result <= r_low ? w_corr[15:0] : w_corr[31:16];
        end
        default: ;
      endcase
    end
  end

  assign mul_m1     = r_m1;
  assign mul_m2     = r_m2;
  assign rsp_result = r_result;

endmodule
